// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 2D-convolution command front-end:
//   - default GPIO / payload widths
//   - opcode encodings carried in the command word
//   - FSM state encodings (also reported in the status word)
//   - bit positions of the command and status word fields
//   - op_legal(): which opcodes a given state accepts
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int NB_GPIO_DEF = 32;
  localparam int NB_DATA_DEF = 24;

  // Command word fields
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 29;
  localparam int TOGGLE_BIT = 28;

  // Status word fields
  localparam int STS_EOP       = 31;
  localparam int STS_STATE_MSB = 30;
  localparam int STS_STATE_LSB = 29;
  localparam int STS_KIDX_MSB  = 28;
  localparam int STS_KIDX_LSB  = 27;
  localparam int STS_ERR       = 26;

  // Kernel row index width; the status field has room for 2 bits.
  localparam int KIDX_W = 2;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_LEN = 3'b001,
    OP_KERNEL  = 3'b010,
    OP_LOAD    = 3'b011,
    OP_DATA    = 3'b100,
    OP_SOP     = 3'b101,
    OP_READ    = 3'b110,
    OP_END     = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_PROC = 2'b10,
    ST_READ = 2'b11
  } state_e;

  // NOP and END are accepted anywhere; everything else is tied to one state.
  function automatic logic op_legal(input opcode_e op, input state_e st);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_NOP, OP_END:                          ok = 1'b1;
      OP_SET_LEN, OP_KERNEL, OP_LOAD, OP_SOP:  ok = (st == ST_IDLE);
      OP_DATA:                                 ok = (st == ST_LOAD);
      OP_READ:                                 ok = (st == ST_READ);
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/read_capture_pipe.sv
// -----------------------------------------------------------------------------
// read_capture_pipe
// Delays the read strobe by DEPTH clock edges; the delayed strobe is the
// enable that captures memory read data into the status word.
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset, empties the pipe
//   strobe_i     : read strobe, asserted in the cycle the READ command executes
//   capture_en_o : high DEPTH edges after strobe_i was registered
// -----------------------------------------------------------------------------
module read_capture_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic capture_en_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign pipe_d = strobe_i;
    end else begin : g_shift
      assign pipe_d = {pipe_q[DEPTH-2:0], strobe_i};
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign capture_en_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder
// Command front-end of the convolution datapath. The soft processor writes
// 32-bit command words over GPIO; this block decodes them into load/start/
// strobe controls, image length, pixel data and kernel rows, and returns a
// status word.
//
// Ports:
//   i_CLK        : clock
//   i_reset      : asynchronous active-high reset
//   i_gpio_data  : command word  [31:29] opcode, [28] toggle, [NB_DATA-1:0] payload
//   i_EoP        : end-of-process level from the address FSM
//   i_memData    : processed-memory read data
//   o_gpio_data  : status word   [31] eop_sticky, [30:29] state, [28:27] kidx,
//                                [26] error, [NB_DATA-1:0] last read data
//   o_imgLength  : image length (last address)
//   o_load       : load mode level
//   o_SoP        : start-of-process level
//   o_valid      : one-cycle DATA / READ strobe
//   o_data       : pixel data to the memories
//   o_kernel     : kernel rows, row 0 in the LSBs
//
// Command handshake: there is no valid/ready pair. A command is "valid" when
// the registered toggle bit differs from the last toggle seen; it is consumed
// in that same cycle (always ready), and the processor must not change the
// word again for at least two cycles. Illegal commands are consumed too, but
// only set the sticky error bit.
//
// FSM state is observable through o_gpio_data[30:29].
// -----------------------------------------------------------------------------
module gpio_cmd_decoder
  import conv_pkg::*;
#(
  parameter int NB_GPIO    = NB_GPIO_DEF,
  parameter int NB_IMAGE   = 10,
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int N_KROWS    = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic                        i_CLK,
  input  logic                        i_reset,
  input  logic [NB_GPIO-1:0]          i_gpio_data,
  input  logic                        i_EoP,
  input  logic [NB_DATA-1:0]          i_memData,
  output logic [NB_GPIO-1:0]          o_gpio_data,
  output logic [NB_IMAGE-1:0]         o_imgLength,
  output logic                        o_load,
  output logic                        o_SoP,
  output logic                        o_valid,
  output logic [NB_DATA-1:0]          o_data,
  output logic [N_KROWS*NB_DATA-1:0]  o_kernel
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [NB_GPIO-1:0]  r_gpio_q;
  logic                sampled_q;
  logic                armed_q, armed_d;
  logic                last_toggle_q, last_toggle_d;
  state_e              state_q, state_d;
  logic [NB_IMAGE-1:0] imglen_q, imglen_d;
  logic [KIDX_W-1:0]   kidx_q, kidx_d;
  logic [NB_DATA-1:0]  kernel_q [N_KROWS];
  logic [NB_DATA-1:0]  kernel_d [N_KROWS];
  logic [NB_DATA-1:0]  data_q, data_d;
  logic [NB_DATA-1:0]  rd_data_q, rd_data_d;
  logic                valid_q, valid_d;
  logic                load_q, sop_q;
  logic                err_q, err_d;
  logic                eop_sticky_q, eop_sticky_d;
  logic                eop_q;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  opcode_e             opcode;
  logic [NB_DATA-1:0]  payload;
  logic                cmd_fire;
  logic                eop_rise, eop_fall;
  logic                rd_stb;
  logic                cap_en;
  logic                unused_gpio_bits;

  assign opcode   = opcode_e'(r_gpio_q[OPC_MSB:OPC_LSB]);
  assign payload  = r_gpio_q[NB_DATA-1:0];
  assign cmd_fire = armed_q & (r_gpio_q[TOGGLE_BIT] ^ last_toggle_q);
  assign eop_rise = i_EoP & ~eop_q;
  assign eop_fall = ~i_EoP & eop_q;

  // Reserved command bits between the toggle and the payload.
  assign unused_gpio_bits = ^r_gpio_q[TOGGLE_BIT-1:NB_DATA];

  // ---------------------------------------------------------------------------
  // Read capture delay line
  // ---------------------------------------------------------------------------
  read_capture_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_read_capture_pipe (
    .clk_i        (i_CLK),
    .rst_i        (i_reset),
    .strobe_i     (rd_stb),
    .capture_en_o (cap_en)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    last_toggle_d = last_toggle_q;
    imglen_d      = imglen_q;
    kidx_d        = kidx_q;
    kernel_d      = kernel_q;
    data_d        = data_q;
    rd_data_d     = rd_data_q;
    err_d         = err_q;
    eop_sticky_d  = eop_sticky_q;
    valid_d       = 1'b0;
    rd_stb        = 1'b0;

    // Arming: r_gpio_q holds a real sample only after the first edge out of
    // reset, so the toggle reference is taken on the edge after that. Any
    // toggle level held through reset is thereby absorbed, not executed.
    if (!armed_q && sampled_q) begin
      armed_d       = 1'b1;
      last_toggle_d = r_gpio_q[TOGGLE_BIT];
    end

    // End-of-process events are evaluated before commands so that an END
    // arriving in the same cycle overrides the PROC->READ move, while the
    // sticky flag still records that the process finished.
    if (state_q == ST_PROC && eop_rise) begin
      state_d      = ST_READ;
      eop_sticky_d = 1'b1;
    end
    if (state_q == ST_READ && eop_fall) begin
      state_d = ST_IDLE;
    end

    if (cmd_fire) begin
      last_toggle_d = r_gpio_q[TOGGLE_BIT];
      if (!op_legal(opcode, state_q)) begin
        err_d = 1'b1;
      end else begin
        case (opcode)
          OP_NOP: ;
          OP_SET_LEN: imglen_d = payload[NB_IMAGE-1:0];
          OP_KERNEL: begin
            for (int r = 0; r < N_KROWS; r++) begin
              if (kidx_q == KIDX_W'(r)) kernel_d[r] = payload;
            end
            kidx_d = (kidx_q == KIDX_W'(N_KROWS-1)) ? '0 : kidx_q + 1'b1;
          end
          OP_LOAD: state_d = ST_LOAD;
          OP_DATA: begin
            data_d  = payload;
            valid_d = 1'b1;
          end
          OP_SOP: begin
            state_d      = ST_PROC;
            eop_sticky_d = 1'b0;
          end
          OP_READ: begin
            valid_d = 1'b1;
            rd_stb  = 1'b1;
          end
          OP_END: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
            kidx_d  = '0;
          end
          default: ;
        endcase
      end
    end

    // Capture runs independently of the command decode so a command arriving
    // while a read is in flight cannot delay or cancel it.
    if (cap_en) begin
      rd_data_d = i_memData;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      r_gpio_q      <= '0;
      sampled_q     <= 1'b0;
      armed_q       <= 1'b0;
      last_toggle_q <= 1'b0;
      state_q       <= ST_IDLE;
      imglen_q      <= '0;
      kidx_q        <= '0;
      for (int r = 0; r < N_KROWS; r++) kernel_q[r] <= '0;
      data_q        <= '0;
      rd_data_q     <= '0;
      valid_q       <= 1'b0;
      load_q        <= 1'b0;
      sop_q         <= 1'b0;
      err_q         <= 1'b0;
      eop_sticky_q  <= 1'b0;
      eop_q         <= 1'b0;
    end else begin
      r_gpio_q      <= i_gpio_data;
      sampled_q     <= 1'b1;
      armed_q       <= armed_d;
      last_toggle_q <= last_toggle_d;
      state_q       <= state_d;
      imglen_q      <= imglen_d;
      kidx_q        <= kidx_d;
      for (int r = 0; r < N_KROWS; r++) kernel_q[r] <= kernel_d[r];
      data_q        <= data_d;
      rd_data_q     <= rd_data_d;
      valid_q       <= valid_d;
      // Both levels follow the next state, so they can never be high together.
      load_q        <= (state_d == ST_LOAD);
      sop_q         <= (state_d == ST_PROC);
      err_q         <= err_d;
      eop_sticky_q  <= eop_sticky_d;
      eop_q         <= i_EoP;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [NB_GPIO-1:0] status;

  always_comb begin
    status                              = '0;
    status[STS_EOP]                     = eop_sticky_q;
    status[STS_STATE_MSB:STS_STATE_LSB] = state_q;
    status[STS_KIDX_MSB:STS_KIDX_LSB]   = kidx_q;
    status[STS_ERR]                     = err_q;
    status[NB_DATA-1:0]                 = rd_data_q;
  end

  assign o_gpio_data = status;
  assign o_imgLength = imglen_q;
  assign o_load      = load_q;
  assign o_SoP       = sop_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;

  generate
    for (genvar r = 0; r < N_KROWS; r++) begin : g_kernel_out
      assign o_kernel[r*NB_DATA +: NB_DATA] = kernel_q[r];
    end
  endgenerate

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_gpio_cmd_decoder
// Directed bench for gpio_cmd_decoder: kernel loading, load mode, illegal
// commands, process/read-back with capture latency, END vs EoP collision,
// and asynchronous reset with re-arming.
// -----------------------------------------------------------------------------
module tb_gpio_cmd_decoder;

  localparam logic [2:0] NOP     = 3'b000;
  localparam logic [2:0] SET_LEN = 3'b001;
  localparam logic [2:0] KERNEL  = 3'b010;
  localparam logic [2:0] LOAD    = 3'b011;
  localparam logic [2:0] DATA    = 3'b100;
  localparam logic [2:0] SOP     = 3'b101;
  localparam logic [2:0] READ    = 3'b110;
  localparam logic [2:0] ENDC    = 3'b111;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        i_CLK = 1'b0;
  logic        i_reset;
  logic [31:0] i_gpio_data;
  logic        i_EoP;
  logic [23:0] i_memData;
  logic [31:0] o_gpio_data;
  logic [9:0]  o_imgLength;
  logic        o_load;
  logic        o_SoP;
  logic        o_valid;
  logic [23:0] o_data;
  logic [71:0] o_kernel;

  always #5 i_CLK = ~i_CLK;

  gpio_cmd_decoder dut (
    .i_CLK       (i_CLK),
    .i_reset     (i_reset),
    .i_gpio_data (i_gpio_data),
    .i_EoP       (i_EoP),
    .i_memData   (i_memData),
    .o_gpio_data (o_gpio_data),
    .o_imgLength (o_imgLength),
    .o_load      (o_load),
    .o_SoP       (o_SoP),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_kernel    (o_kernel)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int   total;
  int   bad;
  logic toggle;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [23:0] pl);
    toggle      = ~toggle;
    i_gpio_data = {op, toggle, 4'h0, pl};
  endtask

  // Issue a command and wait until its effect is visible (after edge N+1).
  task automatic cmd(input logic [2:0] op, input logic [23:0] pl);
    send(op, pl);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, o_gpio_data, 32'h0);
    check({tag, "_len"},    o_imgLength, 10'h0);
    check({tag, "_load"},   o_load,      1'b0);
    check({tag, "_sop"},    o_SoP,       1'b0);
    check({tag, "_valid"},  o_valid,     1'b0);
    check({tag, "_data"},   o_data,      24'h0);
    check({tag, "_kernel"}, o_kernel,    72'h0);
  endtask

  logic [23:0] kp [4];

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    total       = 0;
    bad         = 0;
    toggle      = 1'b0;
    i_reset     = 1'b1;
    i_gpio_data = 32'h0;
    i_EoP       = 1'b0;
    i_memData   = 24'h0;
    kp[0] = 24'h010203;
    kp[1] = 24'h040506;
    kp[2] = 24'h070809;
    kp[3] = 24'h0A0B0C;

    repeat (3) tick();
    check_all_zero("reset");
    i_reset = 1'b0;
    repeat (4) tick();
    check("armed_idle", o_gpio_data, 32'h0);

    // Kernel loading: 4th write wraps back to row 0
    cmd(SET_LEN, 24'h0003FF);
    check("img_len", o_imgLength, 10'h3FF);
    for (int i = 0; i < 4; i++) cmd(KERNEL, kp[i]);
    check("kernel_rows", o_kernel, {24'h070809, 24'h040506, 24'h0A0B0C});
    check("kidx_status", o_gpio_data, 32'h0800_0000);

    // Load mode
    cmd(LOAD, 24'h0);
    check("load_on", o_load, 1'b1);
    check("load_status", o_gpio_data, 32'h2800_0000);
    send(DATA, 24'hABCDEF);
    tick();
    check("data_valid_n", o_valid, 1'b0);
    tick();
    check("data_valid_n1", o_valid, 1'b1);
    check("data_value", o_data, 24'hABCDEF);
    tick();
    check("data_valid_n2", o_valid, 1'b0);
    check("data_hold", o_data, 24'hABCDEF);
    cmd(ENDC, 24'h0);
    check("end_load_off", o_load, 1'b0);
    check("end_status", o_gpio_data, 32'h0);

    // Illegal DATA in IDLE
    send(DATA, 24'h111111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("illegal_no_valid", o_valid, 1'b0);
    end
    check("illegal_err", o_gpio_data, 32'h0400_0000);
    check("illegal_data_kept", o_data, 24'hABCDEF);
    cmd(SOP, 24'h0);
    check("sop_with_err", o_SoP, 1'b1);
    check("sop_err_status", o_gpio_data, 32'h4400_0000);
    cmd(ENDC, 24'h0);
    check("end_clears_err", o_gpio_data, 32'h0);
    check("end_sop_off", o_SoP, 1'b0);

    // Process and read-back
    cmd(SOP, 24'h0);
    check("sop_status", o_gpio_data, 32'h4000_0000);
    check("sop_load_off", o_load, 1'b0);
    i_EoP = 1'b1;
    tick();
    check("eop_sop_off", o_SoP, 1'b0);
    check("eop_status", o_gpio_data, 32'hE000_0000);

    i_memData = 24'hDEAD00;
    send(READ, 24'h0);
    tick();                        // N
    tick();                        // N+1
    check("read_valid", o_valid, 1'b1);
    tick();                        // N+2
    check("read_valid_off", o_valid, 1'b0);
    check("read_not_yet", o_gpio_data, 32'hE000_0000);
    i_memData = 24'h123456;
    tick();                        // N+3
    i_memData = 24'h654321;
    check("read_capture", o_gpio_data, 32'hE012_3456);

    // Second read with a new command arriving while the capture is in flight
    send(READ, 24'h0);
    tick();                        // N
    tick();                        // N+1
    tick();                        // N+2
    i_memData = 24'h0A1B2C;
    send(READ, 24'h0);
    tick();                        // N+3
    i_memData = 24'h000000;
    check("inflight_capture", o_gpio_data, 32'hE00A_1B2C);
    tick();                        // N+4: second READ executes
    check("inflight_valid", o_valid, 1'b1);
    tick();                        // N+5
    i_memData = 24'h5A5A5A;
    tick();                        // N+6
    i_memData = 24'h000000;
    check("second_capture", o_gpio_data, 32'hE05A_5A5A);

    i_EoP = 1'b0;
    tick();
    check("eop_fall_idle", o_gpio_data, 32'h805A_5A5A);

    // END colliding with EoP rising in PROC
    cmd(SOP, 24'h0);
    check("sop_clears_sticky", o_gpio_data, 32'h405A_5A5A);
    send(ENDC, 24'h0);
    tick();                        // N: END sampled
    i_EoP = 1'b1;
    tick();                        // N+1: END executes with EoP rising
    check("end_wins_status", o_gpio_data, 32'h805A_5A5A);
    check("end_wins_sop", o_SoP, 1'b0);
    i_EoP = 1'b0;
    tick();
    tick();

    // Reset in the middle of LOAD with the toggle bit held at 1
    if (toggle) cmd(NOP, 24'h0);
    cmd(LOAD, 24'h0);
    check("preload_toggle", toggle, 1'b1);
    check("preload_on", o_load, 1'b1);
    @(posedge i_CLK);
    #3;
    i_reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) tick();
    i_reset = 1'b0;
    repeat (6) tick();
    check("rearm_no_load", o_load, 1'b0);
    check("rearm_status", o_gpio_data, 32'h0);
    cmd(LOAD, 24'h0);
    check("rearm_load", o_load, 1'b1);
    check("rearm_load_status", o_gpio_data, 32'h2000_0000);
    cmd(ENDC, 24'h0);
    check("final_end", o_load, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
